// File: rtl/float_sign_pkg.sv
// Shared definitions for the float sign unit: operation encodings and sign-bit helper.
package float_sign_pkg;

  typedef enum logic [2:0] {
    MODE_NEG      = 3'd0,
    MODE_ABS      = 3'd1,
    MODE_NABS     = 3'd2,
    MODE_COPYSIGN = 3'd3,
    MODE_ALT      = 3'd4,
    MODE_PASS     = 3'd5
  } mode_e;

  // Sign bit position of an IEEE-754 word of the given width.
  function automatic int sign_bit(input int data_w);
    return data_w - 1;
  endfunction

endpackage

// File: rtl/float_sign_pipe.sv
// Delay line of LATENCY stages carrying {valid, data}; the valid bit
// (MSB) can be synchronously cleared in every stage at once.
module float_sign_pipe #(
  parameter int DW      = 33,
  parameter int LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  logic [DW-1:0] stage_q [LATENCY];
  logic [DW-1:0] stage_d [LATENCY];

  always_comb begin
    stage_d[0] = {d_i[DW-1] & ~clr_i, d_i[DW-2:0]};
    for (int i = 1; i < LATENCY; i++) begin
      stage_d[i] = {stage_q[i-1][DW-1] & ~clr_i, stage_q[i-1][DW-2:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q[LATENCY-1];

endmodule

// File: rtl/float_sign_unit.sv
// Versat functional unit applying a selectable sign operation to an IEEE-754
// word, with a pipelined output and a per-run saturating negative-result counter.
module float_sign_unit
  import float_sign_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              running,
  input  logic              run,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [2:0]        mode,
  output logic [DATA_W-1:0] out0,
  output logic [CNT_W-1:0]  negCount
);

  localparam int SB = sign_bit(DATA_W);

  logic              toggle_q, toggle_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sign_s;
  logic              valid_in;
  logic              valid_last;
  logic [DATA_W:0]   pipe_q;
  logic              unused_in1_mag;

  // Only the sign of in1 matters (COPYSIGN).
  assign unused_in1_mag = ^in1[SB-1:0];

  always_comb begin
    sign_s = in0[SB];
    case (mode_e'(mode))
      MODE_NEG:      sign_s = ~in0[SB];
      MODE_ABS:      sign_s = 1'b0;
      MODE_NABS:     sign_s = 1'b1;
      MODE_COPYSIGN: sign_s = in1[SB];
      MODE_ALT:      sign_s = in0[SB] ^ toggle_q;
      default:       sign_s = in0[SB];
    endcase
  end

  assign valid_in = running & ~run;

  float_sign_pipe #(
    .DW      (DATA_W + 1),
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk   (clk),
    .rst   (rst),
    .clr_i (run),
    .d_i   ({valid_in, sign_s, in0[SB-1:0]}),
    .q_o   (pipe_q)
  );

  assign out0       = pipe_q[DATA_W-1:0];
  assign valid_last = pipe_q[DATA_W];

  always_comb begin
    toggle_d = toggle_q;
    if (run) begin
      toggle_d = 1'b0;
    end else if (running) begin
      toggle_d = ~toggle_q;
    end
  end

  // Clear on run wins over a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    if (run) begin
      cnt_d = '0;
    end else if (valid_last && out0[SB] && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      toggle_q <= toggle_d;
      cnt_q    <= cnt_d;
    end
  end

  assign negCount = cnt_q;

endmodule

// File: tb/tb_float_sign_unit.sv
// Bench for float_sign_unit: four parameterisations share stimulus and are
// compared against a history-based reference model plus directed constants.
module tb_float_sign_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        running = 1'b0;
  logic        run = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;

  always #5 clk = ~clk;

  logic [31:0] o0;  logic [15:0] c0;
  logic [15:0] o1;  logic [15:0] c1;
  logic [63:0] o2;  logic [2:0]  c2;
  logic [31:0] o3;  logic [15:0] c3;

  float_sign_unit #(.DATA_W(32), .LATENCY(1), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .running(running), .run(run), .in0(a[31:0]),
    .in1(b[31:0]), .mode(mode), .out0(o0), .negCount(c0));
  float_sign_unit #(.DATA_W(16), .LATENCY(2), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .running(running), .run(run), .in0(a[15:0]),
    .in1(b[15:0]), .mode(mode), .out0(o1), .negCount(c1));
  float_sign_unit #(.DATA_W(64), .LATENCY(3), .CNT_W(3)) u2 (
    .clk(clk), .rst(rst), .running(running), .run(run), .in0(a),
    .in1(b), .mode(mode), .out0(o2), .negCount(c2));
  float_sign_unit #(.DATA_W(32), .LATENCY(2), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst), .running(running), .run(run), .in0(a[31:0]),
    .in1(b[31:0]), .mode(mode), .out0(o3), .negCount(c3));

  logic [63:0] act_o [4];
  logic [15:0] act_c [4];
  always_comb begin
    act_o[0] = {32'd0, o0};
    act_o[1] = {48'd0, o1};
    act_o[2] = o2;
    act_o[3] = {32'd0, o3};
    act_c[0] = c0;
    act_c[1] = c1;
    act_c[2] = {13'd0, c2};
    act_c[3] = c3;
  end

  localparam int CW [4] = '{32, 16, 64, 32};
  localparam int LW [4] = '{1, 2, 3, 2};
  localparam int CC [4] = '{16, 16, 3, 16};

  int errs = 0;
  int checks = 0;

  // Reference model: per-edge history of computed words and their validity.
  logic [63:0] hist [4][64];
  bit          hv [64];
  int          cnt_m [4];
  bit          tog_m = 1'b0;
  int          pe = 0;

  function automatic logic [63:0] sign_op(input logic [63:0] x, input logic [63:0] y,
                                          input logic [2:0] m, input bit tg, input int w);
    logic [63:0] r;
    logic [63:0] mask;
    bit s;
    s = x[w-1];
    case (m)
      3'd0: s = ~s;
      3'd1: s = 1'b0;
      3'd2: s = 1'b1;
      3'd3: s = y[w-1];
      3'd4: s = s ^ tg;
      default: s = x[w-1];
    endcase
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    r = x & mask;
    r[w-1] = s;
    return r;
  endfunction

  function automatic logic [63:0] exp_o(input int i);
    return hist[i][(pe - LW[i] + 1) & 63];
  endfunction

  always @(posedge clk) begin
    int idx;
    pe = pe + 1;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        for (int k = 0; k < 64; k++) hist[i][k] = '0;
        cnt_m[i] = 0;
      end
      for (int k = 0; k < 64; k++) hv[k] = 1'b0;
      tog_m = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        idx = (pe - LW[i]) & 63;
        if (run) cnt_m[i] = 0;
        else if (hv[idx] && hist[i][idx][CW[i]-1] && cnt_m[i] < ((1 << CC[i]) - 1))
          cnt_m[i] = cnt_m[i] + 1;
      end
      if (run) for (int k = 0; k < 64; k++) hv[k] = 1'b0;
      hv[pe & 63] = running & ~run;
      for (int i = 0; i < 4; i++) hist[i][pe & 63] = sign_op(a, b, mode, tog_m, CW[i]);
      if (run) tog_m = 1'b0;
      else if (running) tog_m = ~tog_m;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [63:0] x;
    rst = 1'b1;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (act_o[i] !== 64'd0 || act_c[i] !== 16'd0) begin
        errs++;
        $display("FAIL reset_init cfg%0d: out0=%h cnt=%0d, need 0/0", i, act_o[i], act_c[i]);
      end
    end
    rst = 1'b0;
    mode = 3'd5;
    running = 1'b1;
    for (int n = 0; n < 6; n++) begin
      a = {$urandom, $urandom};
      tick();
    end
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (act_o[i] !== 64'd0 || act_c[i] !== 16'd0) begin
        errs++;
        $display("FAIL reset_async cfg%0d: out0=%h cnt=%0d, need 0/0", i, act_o[i], act_c[i]);
      end
    end
    tick();
    rst = 1'b0;
    running = 1'b0;
    x = 64'h1234_5678_9ABC_DEF0;
    a = x;
    tick();
    a = '0;
    for (int n = 1; n <= 3; n++) begin
      checks++;
      if (o2 !== ((n == 3) ? x : 64'd0)) begin
        errs++;
        $display("FAIL reset_release_lat3 edge%0d: out0=%h need %h", n, o2,
                 (n == 3) ? x : 64'd0);
      end
      if (n < 3) tick();
    end
  endtask

  task automatic test_neg();
    mode = 3'd0;
    a = 64'h3F80_0000;
    tick();
    checks++;
    if (o0 !== 32'hBF80_0000) begin
      errs++; $display("FAIL neg_one: out0=%h need bf800000", o0);
    end
    a = 64'h7FC0_0001;
    tick();
    checks++;
    if (o0 !== 32'hFFC0_0001) begin
      errs++; $display("FAIL neg_nan: out0=%h need ffc00001", o0);
    end
  endtask

  task automatic test_abs_nabs_copysign();
    mode = 3'd1; a = 64'hBC00;
    tick();
    mode = 3'd2; a = 64'h3C00;
    tick();
    checks++;
    if (o1 !== 16'h3C00) begin
      errs++; $display("FAIL abs16: out0=%h need 3c00", o1);
    end
    mode = 3'd3; a = 64'h3C00; b = 64'h8000;
    tick();
    checks++;
    if (o1 !== 16'hBC00) begin
      errs++; $display("FAIL nabs16: out0=%h need bc00", o1);
    end
    tick();
    checks++;
    if (o1 !== 16'hBC00) begin
      errs++; $display("FAIL copysign16: out0=%h need bc00", o1);
    end
    b = '0;
  endtask

  task automatic test_alt();
    logic [31:0] want [4];
    want = '{32'h4000_0000, 32'hC000_0000, 32'h4000_0000, 32'hC000_0000};
    mode = 3'd4; a = 64'h4000_0000;
    run = 1'b1; running = 1'b1;
    tick();
    run = 1'b0;
    tick();
    for (int n = 0; n < 4; n++) begin
      if (n == 3) running = 1'b0;
      tick();
      checks++;
      if (o3 !== want[n]) begin
        errs++; $display("FAIL alt_seq item%0d: out0=%h need %h", n, o3, want[n]);
      end
    end
    running = 1'b0;
  endtask

  task automatic test_counter();
    mode = 3'd2;
    run = 1'b1; running = 1'b1;
    tick();
    run = 1'b0;
    for (int n = 0; n < 10; n++) begin
      a = {$urandom, $urandom};
      tick();
    end
    running = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (act_c[i] !== ((i == 2) ? 16'd7 : 16'd10)) begin
        errs++;
        $display("FAIL count_nabs cfg%0d: negCount=%0d need %0d", i, act_c[i], (i == 2) ? 7 : 10);
      end
    end
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (act_c[i] !== 16'd0) begin
        errs++; $display("FAIL count_clear cfg%0d: negCount=%0d need 0", i, act_c[i]);
      end
    end
  endtask

  task automatic test_run_collision();
    mode = 3'd2;
    run = 1'b1; running = 1'b1;
    tick();
    run = 1'b0;
    repeat (5) tick();
    run = 1'b1;
    tick();
    run = 1'b0; running = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (act_c[i] !== 16'd0) begin
        errs++; $display("FAIL collision_clear cfg%0d: negCount=%0d need 0", i, act_c[i]);
      end
    end
    repeat (5) tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (act_c[i] !== 16'd0) begin
        errs++; $display("FAIL collision_drain cfg%0d: negCount=%0d need 0", i, act_c[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 8; seg++) begin
      running = 1'b0;
      mode = 3'($urandom_range(0, 7));
      tick();
      run = 1'b1; running = 1'b1;
      tick();
      for (int n = 0; n < 30; n++) begin
        run = ($urandom_range(0, 15) == 0);
        running = ($urandom_range(0, 3) != 0);
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        tick();
        for (int i = 0; i < 4; i++) begin
          checks++;
          if (act_o[i] !== exp_o(i) || act_c[i] !== 16'(cnt_m[i])) begin
            errs++;
            $display("FAIL random seg%0d cyc%0d cfg%0d: out0=%h cnt=%0d need %h/%0d",
                     seg, n, i, act_o[i], act_c[i], exp_o(i), cnt_m[i]);
          end
        end
      end
      run = 1'b0; running = 1'b0;
      repeat (4) tick();
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (act_o[i] !== exp_o(i) || act_c[i] !== 16'(cnt_m[i])) begin
          errs++;
          $display("FAIL random_drain seg%0d cfg%0d: out0=%h cnt=%0d need %h/%0d",
                   seg, i, act_o[i], act_c[i], exp_o(i), cnt_m[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_neg();
    test_abs_nabs_copysign();
    test_alt();
    test_counter();
    test_run_collision();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/float_sign_unit.md
Name: float_sign_unit

Overview:
- Parametrised successor to the single-function sign-negate unit in the Versat unit library.
- Applies one of six sign operations to an IEEE-754 word of configurable width (half/single/double), through a configurable-depth output pipeline.
- Adds a running-gated alternating-sign mode and a saturating counter of negative results per run.
- Instantiated as a Versat functional unit. Inputs come from the datapath; MODE and the counter are config/status registers.

Parameters:
DATA_W, 32, float word width (16, 32 or 64); sign is bit DATA_W-1
LATENCY, 1, pipeline depth in cycles from in0/in1 to out0; legal range 1..8
CNT_W, 16, width of the negative-result counter

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
running  input  1  high while the accelerator is executing
run  input  1  single-cycle pulse at start of a run
in0  input  DATA_W  operand
in1  input  DATA_W  sign source for COPYSIGN mode
mode  input  3  operation select (config register, static during a run)
out0  output  DATA_W  result; annotated with versat latency = LATENCY
negCount  output  CNT_W  number of valid results with sign bit 1 since last run

Behaviour:
- Reset (async, rst high): all pipeline stages, out0, valid shift register, toggle flag and negCount go to 0 immediately. Reset mid-run discards in-flight data; nothing resumes after release.
- Stage-0 function (combinational on in0, in1, mode, toggle), magnitude bits [DATA_W-2:0] always passed unchanged:
  - 0 NEG: sign inverted.
  - 1 ABS: sign forced 0.
  - 2 NABS: sign forced 1.
  - 3 COPYSIGN: sign = in1[DATA_W-1].
  - 4 ALT: sign = in0 sign XOR toggle.
  - 5 PASS: unchanged.
  - 6, 7: behave as PASS.
- No NaN/Inf/denormal special-casing: pure bit operation, payloads preserved, -0 and +0 treated by sign bit alone.
- Pipeline: LATENCY register stages, all update every clock regardless of running. out0 is the last stage. A result computed from inputs at cycle t appears on out0 at cycle t+LATENCY.
- Valid tracking:
  - LATENCY-deep shift register fed by (running & ~run); the valid bit travels with its data.
  - Cleared to all 0 on run, so results from the previous run are never counted.
- Toggle flag (ALT mode):
  - Set to 0 on the cycle run is high.
  - Otherwise inverts every cycle running is high; holds when running is low.
  - The first data cycle after run therefore uses toggle=0 (sign unchanged), the next uses 1, and so on.
- negCount:
  - Cleared to 0 on run.
  - Otherwise increments by 1 when the last-stage valid bit is 1 and out0[DATA_W-1] is 1.
  - Saturates at 2^CNT_W-1 (no wrap).
  - run and an increment in the same cycle: the clear wins and the increment is dropped.
- mode changes while running: output undefined for in-flight items; not supported.
- LATENCY=1 must produce the same timing as a single registered stage.

Decomposition:
- Shared package float_sign_pkg:
  - mode encodings MODE_NEG=0, MODE_ABS=1, MODE_NABS=2, MODE_COPYSIGN=3, MODE_ALT=4, MODE_PASS=5.
  - helper constant SIGN_BIT = DATA_W-1, expressed as a function of the parameter.
- One natural sub-module, float_sign_pipe: a parametrised DATA_W+1 bit (data + valid) delay line of LATENCY stages with async reset and synchronous clear of the valid bit.
- Sign-function mux and counter stay in the top module.

Test Plan:
- Reset: assert rst mid-stream with LATENCY=3 -> out0=0 and negCount=0 in the same cycle; after release the first new input appears 3 cycles later.
- NEG, DATA_W=32, LATENCY=1: in0=0x3F800000 -> out0=0xBF800000 next cycle; in0=0x7FC00001 (NaN) -> 0xFFC00001.
- ABS/NABS/COPYSIGN, DATA_W=16: in0=0xBC00 ABS -> 0x3C00; in0=0x3C00 NABS -> 0xBC00; in0=0x3C00 with in1=0x8000 COPYSIGN -> 0xBC00.
- ALT, LATENCY=2: run pulse, then 4 running cycles of in0=0x40000000 -> out0 sequence 0x40000000, 0xC0000000, 0x40000000, 0xC0000000 starting 2 cycles after first input.
- Counter: DATA_W=64, NABS, 10 running cycles -> negCount=10 after LATENCY drain. A new run pulse -> 0. CNT_W=3 with 10 negatives -> saturates at 7.
- Run collision: run asserted on the cycle a negative valid result exits -> negCount=0 next cycle. Results already in the pipe from before run are not counted.
